// File: rtl/vec_scalar_mac_if.sv
// Handshake and data bundle between the MVM controller (master) and the
// vector-scalar MAC engine (slave).
interface vec_scalar_mac_if #(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACCUMULATIONS = 3
);
  localparam int ACC_RAW   = 2*WIDTH + $clog2(ACCUMULATIONS);
  localparam int ACC_WIDTH = (ACC_RAW < 2*WIDTH+1) ? 2*WIDTH+1 : ACC_RAW;

  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [SIZE*WIDTH-1:0]     a;
  logic [WIDTH-1:0]          b;
  logic [SIZE*ACC_WIDTH-1:0] out;
  logic                      done;

  modport master (output start, in_valid, a, b, input in_ready, out, done);
  modport slave  (input start, in_valid, a, b, output in_ready, out, done);
endinterface

// File: rtl/vec_scalar_mac.sv
// Vector-scalar MAC: per accepted beat, SIZE signed products a[i]*b are
// registered, then summed into SIZE accumulators over ACCUMULATIONS beats.
//
// state | meaning
// IDLE  | waiting for start, no beats accepted
// ACCUM | accepting beats until the last one of the job
// DRAIN | last registered product being accumulated
// DONE  | done pulse, out final; start here chains the next job
module vec_scalar_mac #(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACCUMULATIONS = 3
) (
  input  logic            clk,
  input  logic            reset,
  vec_scalar_mac_if.slave bus
);
  localparam int ACC_RAW   = 2*WIDTH + $clog2(ACCUMULATIONS);
  localparam int ACC_WIDTH = (ACC_RAW < 2*WIDTH+1) ? 2*WIDTH+1 : ACC_RAW;
  localparam int PROD_WIDTH = 2*WIDTH;
  localparam int CNT_WIDTH = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(ACCUMULATIONS-1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                       state, state_nxt;
  logic                         in_ready_c, done_c, clear_acc, accept;
  logic [CNT_WIDTH-1:0]         beat_cnt;
  logic                         p_valid;
  logic signed [PROD_WIDTH-1:0] a_ext [SIZE];
  logic signed [PROD_WIDTH-1:0] b_ext;
  logic signed [PROD_WIDTH-1:0] p     [SIZE];
  logic signed [ACC_WIDTH-1:0]  acc   [SIZE];
  logic [SIZE*ACC_WIDTH-1:0]    out_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ACCUM;
      ACCUM:   if (accept && beat_cnt == LAST_BEAT) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = bus.start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = (state == ACCUM);
    done_c     = (state == DONE);
    clear_acc  = bus.start && (state == IDLE || state == DONE);
  end

  assign accept       = bus.in_valid && in_ready_c;
  assign bus.in_ready = in_ready_c;
  assign bus.done     = done_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          beat_cnt <= '0;
    else if (clear_acc) beat_cnt <= '0;
    else if (accept)    beat_cnt <= beat_cnt + 1'b1;
  end

  // Operands widened first so the multiply is PROD_WIDTH x PROD_WIDTH; the
  // low PROD_WIDTH bits are the exact signed product.
  always_comb begin
    b_ext = {{(PROD_WIDTH-WIDTH){bus.b[WIDTH-1]}}, bus.b};
    for (int i = 0; i < SIZE; i++) begin
      a_ext[i] = {{(PROD_WIDTH-WIDTH){bus.a[i*WIDTH+WIDTH-1]}}, bus.a[i*WIDTH +: WIDTH]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      for (int i = 0; i < SIZE; i++) p[i] <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        for (int i = 0; i < SIZE; i++) p[i] <= a_ext[i] * b_ext;
      end
    end
  end

  // A clearing start can only occur in IDLE/DONE, where p_valid is already 0,
  // so clear never races a pending product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) acc[i] <= '0;
    end else if (clear_acc) begin
      for (int i = 0; i < SIZE; i++) acc[i] <= '0;
    end else if (p_valid) begin
      for (int i = 0; i < SIZE; i++)
        acc[i] <= acc[i] + {{(ACC_WIDTH-PROD_WIDTH){p[i][PROD_WIDTH-1]}}, p[i]};
    end
  end

  always_comb begin
    out_c = '0;
    for (int i = 0; i < SIZE; i++) out_c[i*ACC_WIDTH +: ACC_WIDTH] = acc[i];
  end

  assign bus.out = out_c;
endmodule

// File: tb/tb_vec_scalar_mac.sv
// Directed bench for vec_scalar_mac: hand-computed lane sums and done timing
// relative to the last accepted beat.
module tb_vec_scalar_mac;
  localparam int SIZE          = 6;
  localparam int WIDTH         = 8;
  localparam int ACCUMULATIONS = 3;
  localparam int ACC_WIDTH     = 18;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  vec_scalar_mac_if #(.SIZE(SIZE), .WIDTH(WIDTH), .ACCUMULATIONS(ACCUMULATIONS)) bus ();

  vec_scalar_mac #(.SIZE(SIZE), .WIDTH(WIDTH), .ACCUMULATIONS(ACCUMULATIONS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [SIZE*WIDTH-1:0] a_fill(input int v);
    logic [SIZE*WIDTH-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
    return r;
  endfunction

  function automatic logic [SIZE*WIDTH-1:0] a_ramp();
    logic [SIZE*WIDTH-1:0] r;
    int v;
    for (int i = 0; i < SIZE; i++) begin
      v = i + 1;
      r[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic [SIZE*ACC_WIDTH-1:0] out_fill(input int v);
    logic [SIZE*ACC_WIDTH-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*ACC_WIDTH +: ACC_WIDTH] = v[ACC_WIDTH-1:0];
    return r;
  endfunction

  function automatic logic [SIZE*ACC_WIDTH-1:0] out_ramp(input int mult);
    logic [SIZE*ACC_WIDTH-1:0] r;
    int v;
    for (int i = 0; i < SIZE; i++) begin
      v = (i + 1) * mult;
      r[i*ACC_WIDTH +: ACC_WIDTH] = v[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [SIZE*WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    if (bus.out !== out_fill(0)) begin $display("FAIL reset_out: got %h want 0", bus.out); n_bad++; end
    n_cmp++;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
      $display("FAIL reset_ctl: got done=%b in_ready=%b want 0/0", bus.done, bus.in_ready); n_bad++;
    end
    n_cmp++;
    reset = 1'b0;
    tick();
    start_pulse();
    beat(a_ramp(), 8'd2);
    tick();
    if (bus.out !== out_ramp(2)) begin $display("FAIL reset_pre_acc: got %h want %h", bus.out, out_ramp(2)); n_bad++; end
    n_cmp++;
    #2 reset = 1'b1;
    #1;
    if (bus.out !== out_fill(0) || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset_async: got out=%h in_ready=%b done=%b want 0/0/0", bus.out, bus.in_ready, bus.done); n_bad++;
    end
    n_cmp++;
    #2 reset = 1'b0;
    tick();
    if (bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset_idle: got in_ready=%b done=%b want 0/0", bus.in_ready, bus.done); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    start_pulse();
    if (bus.in_ready !== 1'b1) begin $display("FAIL basic_ready: got %b want 1", bus.in_ready); n_bad++; end
    n_cmp++;
    for (int k = 0; k < ACCUMULATIONS; k++) beat(a_ramp(), 8'd2);
    if (bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL basic_drain: got in_ready=%b done=%b want 0/0", bus.in_ready, bus.done); n_bad++;
    end
    n_cmp++;
    tick();
    if (bus.done !== 1'b1) begin $display("FAIL basic_done: got %b want 1", bus.done); n_bad++; end
    n_cmp++;
    if (bus.out !== out_ramp(6)) begin $display("FAIL basic_out: got %h want %h", bus.out, out_ramp(6)); n_bad++; end
    n_cmp++;
    tick();
    if (bus.done !== 1'b0 || bus.out !== out_ramp(6)) begin
      $display("FAIL basic_hold: got done=%b out=%h want 0/%h", bus.done, bus.out, out_ramp(6)); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_signed();
    start_pulse();
    for (int k = 0; k < ACCUMULATIONS; k++) beat(a_fill(-128), 8'h80);
    tick();
    if (bus.done !== 1'b1 || bus.out !== out_fill(49152)) begin
      $display("FAIL signed_neg_neg: got done=%b out=%h want 1/%h", bus.done, bus.out, out_fill(49152)); n_bad++;
    end
    n_cmp++;
    tick();
    start_pulse();
    for (int k = 0; k < ACCUMULATIONS; k++) beat(a_fill(127), 8'h80);
    tick();
    if (bus.done !== 1'b1 || bus.out !== out_fill(-48768)) begin
      $display("FAIL signed_pos_neg: got done=%b out=%h want 1/%h", bus.done, bus.out, out_fill(-48768)); n_bad++;
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_gapped();
    bus.in_valid = 1'b1;
    bus.a        = a_fill(50);
    bus.b        = 8'd3;
    tick();
    tick();
    bus.in_valid = 1'b0;
    if (bus.out !== out_fill(-48768)) begin
      $display("FAIL gap_idle_valid: got %h want %h", bus.out, out_fill(-48768)); n_bad++;
    end
    n_cmp++;
    start_pulse();
    repeat (5) tick();
    beat(a_ramp(), 8'd2);
    beat(a_ramp(), 8'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    beat(a_ramp(), 8'd2);
    bus.in_valid = 1'b1;
    bus.a        = a_fill(50);
    bus.b        = 8'd3;
    if (bus.done !== 1'b0) begin $display("FAIL gap_drain: got done=%b want 0", bus.done); n_bad++; end
    n_cmp++;
    tick();
    if (bus.done !== 1'b1 || bus.out !== out_ramp(6)) begin
      $display("FAIL gap_done: got done=%b out=%h want 1/%h", bus.done, bus.out, out_ramp(6)); n_bad++;
    end
    n_cmp++;
    tick();
    bus.in_valid = 1'b0;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b0 || bus.out !== out_ramp(6)) begin
      $display("FAIL gap_after: got done=%b in_ready=%b out=%h want 0/0/%h", bus.done, bus.in_ready, bus.out, out_ramp(6)); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    start_pulse();
    for (int k = 0; k < ACCUMULATIONS; k++) beat(a_ramp(), 8'd2);
    tick();
    if (bus.done !== 1'b1 || bus.out !== out_ramp(6)) begin
      $display("FAIL b2b_first: got done=%b out=%h want 1/%h", bus.done, bus.out, out_ramp(6)); n_bad++;
    end
    n_cmp++;
    start_pulse();
    if (bus.out !== out_fill(0) || bus.in_ready !== 1'b1) begin
      $display("FAIL b2b_clear: got out=%h in_ready=%b want 0/1", bus.out, bus.in_ready); n_bad++;
    end
    n_cmp++;
    for (int k = 0; k < ACCUMULATIONS; k++) beat(a_fill(1), 8'd1);
    tick();
    if (bus.done !== 1'b1 || bus.out !== out_fill(3)) begin
      $display("FAIL b2b_second: got done=%b out=%h want 1/%h", bus.done, bus.out, out_fill(3)); n_bad++;
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_reset_mid_job();
    start_pulse();
    beat(a_ramp(), 8'd2);
    beat(a_ramp(), 8'd2);
    #2 reset = 1'b1;
    #1;
    if (bus.out !== out_fill(0) || bus.in_ready !== 1'b0) begin
      $display("FAIL mid_reset: got out=%h in_ready=%b want 0/0", bus.out, bus.in_ready); n_bad++;
    end
    n_cmp++;
    reset = 1'b0;
    tick();
    start_pulse();
    for (int k = 0; k < ACCUMULATIONS; k++) beat(a_fill(1), 8'd1);
    if (bus.done !== 1'b0) begin $display("FAIL mid_drain: got done=%b want 0", bus.done); n_bad++; end
    n_cmp++;
    tick();
    if (bus.done !== 1'b1 || bus.out !== out_fill(3)) begin
      $display("FAIL mid_fresh: got done=%b out=%h want 1/%h", bus.done, bus.out, out_fill(3)); n_bad++;
    end
    n_cmp++;
    tick();
    if (bus.done !== 1'b0) begin $display("FAIL mid_pulse: got done=%b want 0", bus.done); n_bad++; end
    n_cmp++;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    reset        = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_gapped();
    test_back_to_back();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vec_scalar_mac.md
# vec_scalar_mac

Vector-scalar multiply-accumulate engine that performs the arithmetic for the matrix-vector multiplier. Each accepted beat multiplies one matrix column by one vector element. SIZE signed products are summed into SIZE accumulators over ACCUMULATIONS beats, then the block signals done. It sits directly under the MVM controller, which issues start, streams column/element pairs, and waits for done.

## Interface
- SIZE, 6: number of lanes, equal to the matrix row count.
- WIDTH, 8: signed two's-complement width of each operand.
- ACCUMULATIONS, 3: beats per job, equal to the shared dimension; must be ≥ 1.
- ACC_WIDTH (localparam) = 2*WIDTH + $clog2(ACCUMULATIONS), minimum 2*WIDTH+1: signed accumulator width per lane.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a job; sampled only in IDLE or DONE.
- in_valid  in  1  a/b beat present.
- in_ready  out  1  beat accepted on an edge where in_valid && in_ready.
- a  in  SIZE*WIDTH  column vector; lane i is a[i*WIDTH +: WIDTH].
- b  in  WIDTH  scalar, shared by all lanes.
- out  out  SIZE*ACC_WIDTH  accumulated results; lane i is out[i*ACC_WIDTH +: ACC_WIDTH].
- done  out  1  one-cycle pulse; out is valid while done=1 and holds until the next start.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE. Reset state is IDLE.
- IDLE
  - in_ready=0.
  - On start: clear all accumulators to 0, set beat_cnt=0, go to ACCUM.
- ACCUM
  - in_ready=1.
  - Each accepted beat registers SIZE products p[i] = a[i]*b (signed, 2*WIDTH bits) into stage 1, sets p_valid=1, and increments beat_cnt.
  - When the beat with beat_cnt==ACCUMULATIONS-1 is accepted, go to DRAIN; in_ready drops from that edge.
- Stage 2 (any state)
  - When p_valid=1: acc[i] += sign-extend(p[i]) to ACC_WIDTH.
  - The sum is exact; overflow cannot occur by construction.
- DRAIN
  - in_ready=0.
  - The last product is accumulated on this edge; go to DONE.
- DONE
  - done=1 for this single cycle; in_ready=0.
  - With start: clear accumulators, go to ACCUM (back-to-back jobs).
  - Without start: go to IDLE.
- out drives the accumulator registers directly. Its value is unchanged from DONE until the next start edge.
- Ignored inputs:
  - in_valid while in_ready=0 (no product, no count).
  - start in ACCUM or DRAIN.
- Reset at any time, including mid-job:
  - state=IDLE, accumulators=0, beat_cnt=0, p_valid=0.
  - Any partial job is discarded.

## Timing
- Reset values: out=0, done=0, in_ready=0.
- Start sampled at edge S puts the block in ACCUM from S. The earliest first beat is accepted at edge S+1.
- Last beat accepted at edge k:
  - DRAIN during k..k+1.
  - Accumulation completes at edge k+1.
  - done=1 and out final during the cycle after edge k+1.
- Back-to-back input (one beat per cycle, ACCUMULATIONS=3, start at edge 0):
  - Beats at edges 1, 2, 3.
  - done high in the cycle after edge 4.
  - Total latency is start + ACCUMULATIONS + 1 cycles.
- Gaps in in_valid stretch ACCUM only. The timing from the last beat to done is always fixed.
- Throughput: one job per ACCUMULATIONS+2 cycles with start held asserted in DONE.

## Test plan
- Reset: assert reset mid-cycle, asynchronously -> out=0, done=0, in_ready=0 immediately; state is IDLE after release.
- Basic job (defaults): a lanes = 1,2,3,4,5,6, b=2, three back-to-back beats -> out lanes = 6,12,18,24,30,36. done is one cycle, exactly 2 edges after the last beat.
- Signed extremes: all lanes a=-128, b=-128, three beats -> every lane = 49152. Then a=127, b=-128 x3 -> every lane = -48768, with no wrap.
- Gapped and ignored input:
  - Beats separated by 0, 2 and 5 idle cycles give the same result as back-to-back.
  - in_valid pulses in IDLE/DRAIN/DONE and start pulses in ACCUM leave the result and beat count unchanged.
- Back-to-back jobs: start held during DONE -> accumulators clear. The second job (a lanes=1, b=1) yields 3 per lane with no carry-over from the first.
- Reset mid-ACCUM after 2 beats, then a fresh job (a lanes=1, b=1) -> out=3 per lane and done is correctly timed.
